lcd_bus_scheduler: RTL

//  Shares one HD44780 8-bit LCD bus between two write requesters: req0 (init/command sequencer) and req1 (text/CRC writer).

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_req_arbiter.sv | 40 ++++
 rtl/lcd_bus_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus scheduler.
package lcd_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, HOLD, WAIT} lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int CNT_W = 20;

  localparam int DEF_T_SETUP_CYC = 3;
  localparam int DEF_T_EN_CYC    = 25;
  localparam int DEF_T_HOLD_CYC  = 2;
  localparam int DEF_T_CMD_CYC   = 2000;
  localparam int DEF_T_CLR_CYC   = 82000;

  // Clear and both home encodings (02/03) need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_req_arbiter.sv
// Two-way grant logic. LCD_PRIO_ROTATE_EN selects round-robin, else req0 > req1.
module lcd_req_arbiter
  import lcd_pkg::*;
(
`ifdef LCD_PRIO_ROTATE_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] ready
);

`ifdef LCD_PRIO_ROTATE_EN
  // prio1 set means req1 wins the next conflict
  logic prio1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio1 <= 1'b0;
    else if (|ready) prio1 <= ready[0];
  end

  always_comb begin
    ready = '0;
    if (enable) begin
      if (&valid) ready = prio1 ? 2'b10 : 2'b01;
      else        ready = valid;
    end
  end
`else
  always_comb begin
    ready = '0;
    if (enable) begin
      ready[0] = valid[0];
      ready[1] = valid[1] & ~valid[0];
    end
  end
`endif

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares one HD44780 8-bit write bus between two requesters with timed EN strobes.
// Optional macro LCD_PRIO_ROTATE_EN switches arbitration to round-robin.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = DEF_T_SETUP_CYC,
  parameter int T_EN_CYC    = DEF_T_EN_CYC,
  parameter int T_HOLD_CYC  = DEF_T_HOLD_CYC,
  parameter int T_CMD_CYC   = DEF_T_CMD_CYC,
  parameter int T_CLR_CYC   = DEF_T_CLR_CYC
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       busy,
  output logic       grant_id
);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ready;
  logic             accept;

  lcd_req_arbiter u_arb (
`ifdef LCD_PRIO_ROTATE_EN
    .clk    (Clock),
    .rst_n  (Reset_n),
`endif
    .enable (state_q == IDLE),
    .valid  ({req1_valid, req0_valid}),
    .ready  (ready)
  );

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign accept     = |ready;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is loaded with N-1 so each timed state lasts exactly N cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        cnt_d   = CNT_W'(T_SETUP_CYC - 1);
      end
      SETUP: if (cnt_q == '0) begin
        state_d = EN_HIGH;
        cnt_d   = CNT_W'(T_EN_CYC - 1);
      end else cnt_d = cnt_q - 1'b1;
      EN_HIGH: if (cnt_q == '0) begin
        state_d = HOLD;
        cnt_d   = CNT_W'(T_HOLD_CYC - 1);
      end else cnt_d = cnt_q - 1'b1;
      HOLD: if (cnt_q == '0) begin
        state_d = WAIT;
        cnt_d   = is_slow_cmd(LCD_RS, LCD_DATA) ? CNT_W'(T_CLR_CYC - 1)
                                                : CNT_W'(T_CMD_CYC - 1);
      end else cnt_d = cnt_q - 1'b1;
      WAIT: if (cnt_q == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q - 1'b1;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    LCD_EN = (state_q == EN_HIGH);
    busy   = (state_q != IDLE);
  end

  assign LCD_RW = 1'b0;

  // Bus byte and owner are captured only on the accept edge and held while idle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      LCD_RS   <= 1'b0;
      LCD_DATA <= '0;
      grant_id <= 1'b0;
    end else if (accept) begin
      LCD_RS   <= ready[1] ? req1_rs   : req0_rs;
      LCD_DATA <= ready[1] ? req1_data : req0_data;
      grant_id <= ready[1];
    end
  end

endmodule
